// File: rtl/aes_req_sched.sv
// Shares one aes_if engine between NUM_REQ requesters: round-robin accept, LOAD 1 cycle, RUN until the
// second TRIGGER_EXT fall or TIMEOUT (then 2-cycle engine reset); the tagged response is held until rsp_ready_i.
module aes_req_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [128*NUM_REQ-1:0] req_pt_i,
  input  logic [256*NUM_REQ-1:0] req_key_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [IDW-1:0]         rsp_id_o,
  output logic [127:0]           rsp_data_o,
  output logic                   rsp_err_o,
  output logic [386:0]           eng_scan_chain_o,
  output logic                   eng_enable_o,
  output logic                   eng_rst_n_o,
  input  logic                   eng_trigger_i,
  input  logic [386:0]           eng_ct_i
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, RECOVER, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  idx;
  logic            win_vld;
  logic            trig_q;
  logic [1:0]      edges;
  logic [CW-1:0]   cyc;
  logic            rise;
  logic            fall;
  logic            unused_ct;

  assign rise      = eng_trigger_i & ~trig_q;
  assign fall      = ~eng_trigger_i & trig_q;
  assign unused_ct = ^eng_ct_i[386:128];

  // Search upward from last+1 with wrap; the first valid requester wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(last) + i) % NUM_REQ);
      if (!win_vld && req_valid_i[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (RST_N && state == IDLE && win_vld) req_ready_o[win] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state            <= IDLE;
      last             <= IDW'(NUM_REQ - 1);
      id_q             <= '0;
      trig_q           <= 1'b0;
      edges            <= '0;
      cyc              <= '0;
      rsp_valid_o      <= 1'b0;
      rsp_id_o         <= '0;
      rsp_data_o       <= '0;
      rsp_err_o        <= 1'b0;
      eng_scan_chain_o <= '0;
      eng_enable_o     <= 1'b0;
      eng_rst_n_o      <= 1'b0;
    end else begin
      trig_q      <= eng_trigger_i;
      eng_rst_n_o <= 1'b1;
      case (state)
        IDLE: begin
          if (win_vld) begin
            // The scan chain register doubles as the pt/key capture.
            last             <= win;
            id_q             <= win;
            eng_scan_chain_o <= {req_pt_i[win*128 +: 128], req_key_i[win*256 +: 256], 3'b110};
            edges            <= '0;
            state            <= LOAD;
          end
        end
        LOAD: begin
          edges        <= '0;
          cyc          <= '0;
          eng_enable_o <= 1'b1;
          state        <= RUN;
        end
        RUN: begin
          if (fall && edges == 2'd2) begin
            rsp_valid_o      <= 1'b1;
            rsp_id_o         <= id_q;
            rsp_data_o       <= eng_ct_i[127:0];
            rsp_err_o        <= 1'b0;
            eng_enable_o     <= 1'b0;
            eng_scan_chain_o <= '0;
            state            <= RESP;
          end else if (cyc == CW'(TIMEOUT - 1)) begin
            cyc              <= '0;
            rsp_data_o       <= '0;
            rsp_err_o        <= 1'b1;
            eng_enable_o     <= 1'b0;
            eng_scan_chain_o <= '0;
            eng_rst_n_o      <= 1'b0;
            state            <= RECOVER;
          end else begin
            cyc <= cyc + 1'b1;
            if (rise && edges != 2'd2) edges <= edges + 1'b1;
          end
        end
        RECOVER: begin
          if (cyc == CW'(1)) begin
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= id_q;
            state       <= RESP;
          end else begin
            cyc         <= cyc + 1'b1;
            eng_rst_n_o <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_req_sched.md
# aes_req_sched

Request scheduler that shares one `aes_if` encryption engine between `NUM_REQ` independent requesters. It arbitrates round-robin and captures the winner's plaintext/key. It then builds the 387-bit scan chain, sequences the engine's `ENABLE`, and tracks the two-pulse `TRIGGER_EXT` completion protocol. The ciphertext is returned tagged with the requester ID, and a hung engine is recovered through a timeout and local engine reset. The block sits between the host-side request ports and the `aes_if` instance, replacing ad-hoc per-client sequencing.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8); `IDW = $clog2(NUM_REQ)`.
- `TIMEOUT`, 1024: maximum cycles in RUN before abort (≥ 8).
- `CLK`  in  1  single clock; all logic rising-edge.
- `RST_N`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  one-hot accept strobe; plaintext/key are captured on `valid & ready`.
- `req_pt_i`  in  128*NUM_REQ  plaintext; requester k is at bits [128k+127:128k].
- `req_key_i`  in  256*NUM_REQ  key; requester k is at bits [256k+255:256k].
- `rsp_valid_o`  out  1  response valid; held until accepted.
- `rsp_ready_i`  in  1  response accept.
- `rsp_id_o`  out  IDW  ID of the requester being answered.
- `rsp_data_o`  out  128  ciphertext; 0 on error.
- `rsp_err_o`  out  1  1 = engine timed out.
- `eng_scan_chain_o`  out  387  engine scan chain: {pt, key, pt_sel, key_sel, ct_out_sel}.
- `eng_enable_o`  out  1  engine ENABLE.
- `eng_rst_n_o`  out  1  engine RST_N.
- `eng_trigger_i`  in  1  engine TRIGGER_EXT.
- `eng_ct_i`  in  387  engine CIPHERTEXT; only [127:0] is used.

## Operation
- States:
  - IDLE → LOAD: when any request is present, the winner is accepted.
  - LOAD → RUN: after 1 cycle.
  - RUN → RESP: on completion.
  - RUN → RECOVER: on timeout.
  - RECOVER → RESP: after 2 cycles.
  - RESP → IDLE: when `rsp_valid_o & rsp_ready_i`.
- Arbitration (IDLE only):
  - Round-robin, searching from `last+1` upward with wrap at NUM_REQ−1 → 0.
  - `req_ready_o` is combinational: one-hot on the winner in IDLE, otherwise 0.
  - `last` updates to the winner on accept. No request means the block stays in IDLE with outputs unchanged.
- Capture: on accept, the block registers pt, key and ID; the request inputs are then ignored until the next IDLE.
- Scan chain:
  - LOAD, RUN: `{pt_q, key_q, 1'b1, 1'b1, 1'b0}`, held constant.
  - All other states: all zeros.
- Enable: `eng_enable_o` = 1 only in RUN.
- Trigger tracking:
  - `trig_q` is `eng_trigger_i` registered; rise = `trig & ~trig_q`, fall = `~trig & trig_q`.
  - A 2-bit edge counter is cleared in LOAD and increments on each rise in RUN, saturating at 2.
  - Completion is a fall while the counter is 2. On completion, `eng_ct_i[127:0]` is captured into `rsp_data_o` and `rsp_err_o` is set to 0.
  - A single pulse, or a second rise without a fall, is not completion.
- Timeout:
  - A cycle counter is cleared on entering RUN and increments each RUN cycle.
  - If it reaches TIMEOUT−1 with no completion in that cycle, the block enters RECOVER.
  - In RECOVER: `eng_rst_n_o` = 0, `eng_enable_o` = 0, `rsp_data_o` = 0, `rsp_err_o` = 1.
- Engine reset: `eng_rst_n_o` = `RST_N & ~(state==RECOVER)`, registered.
- Response: `rsp_valid_o` = 1 in RESP; `rsp_id_o`, `rsp_data_o` and `rsp_err_o` are stable while valid and not accepted.

## Timing
- Reset values:
  - State IDLE, `last` = NUM_REQ−1, so requester 0 wins first.
  - `req_ready_o`, `rsp_valid_o`, `rsp_id_o`, `rsp_data_o`, `rsp_err_o`, `eng_scan_chain_o`, `eng_enable_o`, `trig_q` and all counters = 0.
  - `eng_rst_n_o` = 0 during reset, then 1 from the first cycle after `RST_N` rises.
- Latency, with the accept cycle as T0:
  - LOAD at T1, with the scan chain valid.
  - RUN from T2, with enable high.
  - RESP, with `rsp_valid_o` = 1, in the cycle after the completing fall is detected.
- Minimum throughput: one request per (engine time + 4) cycles. A new accept is possible in the cycle after response acceptance.
- Simultaneous events:
  - Completion in the same cycle as the timeout terminal count: completion wins, with err = 0.
  - Trigger edges outside RUN are ignored.
- Reset mid-operation, in any state: next cycle IDLE with all reset values. Pending requesters are re-arbitrated from requester 0.

## Test plan
- Single request: requester 0 sends pt=0x00112233445566778899aabbccddeeff with key 0x000102…1f. The engine model pulses trigger twice. Required: `req_ready_o`=4'b0001 at T0, LOAD at T1, enable from T2; a scan chain ending 3'b110; a response with id=0, err=0 and data = model ct[127:0].
- Round-robin: requesters 1 and 3 valid continuously from reset. Required: grant order 1,3,1,3 across four responses, with no requester granted twice in a row.
- Backpressure: `rsp_ready_i` held low for 10 cycles after RESP. Required: `rsp_valid_o` and data stable for 10 cycles, no new `req_ready_o`, and IDLE in the cycle after the handshake.
- Timeout: trigger stuck at 0, TIMEOUT=16. Required: RECOVER 16 cycles after RUN entry, `eng_rst_n_o` low for exactly 2 cycles, then a response with err=1 and data=0.
- Single pulse: one trigger pulse only. Required: no completion, and a timeout response with err=1.
- Reset mid-RUN: `RST_N` low for 1 cycle after the first trigger rise. Required: next cycle IDLE, all outputs 0, and the subsequent request handled normally with counters cleared.
